// File: rtl/centroid_moment_accu.sv
// Frame-based zeroth/first image moment accumulator (m00, m10, m01) with sticky overflow flag.
// Optional macro CENTROID_ACCU_SATURATE_EN: clamp overflowing accumulators to all-ones instead of wrapping.
module centroid_moment_accu #(
    parameter int XW = 11,
    parameter int YW = 11,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          sof,
    input  logic          eof,
    input  logic          mask,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [AW-1:0] m00,
    output logic [AW-1:0] m10,
    output logic [AW-1:0] m01,
    output logic          ovf,
    output logic          out_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          take, publish;
    logic [AW-1:0] acc00_q, acc00_d, acc10_q, acc10_d, acc01_q, acc01_d;
    logic          ovf_acc_q, ovf_acc_d;
    logic [AW-1:0] m00_q, m00_d, m10_q, m10_d, m01_q, m01_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] base00, base10, base01;
    logic [AW-1:0] inc00, inc10, inc01;
    logic [AW:0]   sum00, sum10, sum01;
    logic [AW-1:0] new00, new10, new01;
    logic          new_ovf;

    // A sample is consumed when ce is high and either a frame is open or one is starting.
    assign take    = ce && ((state_q == ACCUM) || sof);
    assign publish = take && eof;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (take) state_d = eof ? IDLE : ACCUM;
    end

    always_comb begin
        // sof discards whatever was accumulated, both when opening and when restarting a frame.
        base00 = sof ? '0 : acc00_q;
        base10 = sof ? '0 : acc10_q;
        base01 = sof ? '0 : acc01_q;
        inc00  = {{(AW-1){1'b0}}, mask};
        inc10  = mask ? {{(AW-XW){1'b0}}, x} : '0;
        inc01  = mask ? {{(AW-YW){1'b0}}, y} : '0;
        sum00  = {1'b0, base00} + {1'b0, inc00};
        sum10  = {1'b0, base10} + {1'b0, inc10};
        sum01  = {1'b0, base01} + {1'b0, inc01};
`ifdef CENTROID_ACCU_SATURATE_EN
        new00  = sum00[AW] ? '1 : sum00[AW-1:0];
        new10  = sum10[AW] ? '1 : sum10[AW-1:0];
        new01  = sum01[AW] ? '1 : sum01[AW-1:0];
`else
        new00  = sum00[AW-1:0];
        new10  = sum10[AW-1:0];
        new01  = sum01[AW-1:0];
`endif
        new_ovf = (sof ? 1'b0 : ovf_acc_q) | sum00[AW] | sum10[AW] | sum01[AW];

        acc00_d     = acc00_q;
        acc10_d     = acc10_q;
        acc01_d     = acc01_q;
        ovf_acc_d   = ovf_acc_q;
        m00_d       = m00_q;
        m10_d       = m10_q;
        m01_d       = m01_q;
        ovf_d       = ovf_q;
        out_valid_d = publish;
        if (take) begin
            acc00_d   = new00;
            acc10_d   = new10;
            acc01_d   = new01;
            ovf_acc_d = new_ovf;
        end
        if (publish) begin
            m00_d = new00;
            m10_d = new10;
            m01_d = new01;
            ovf_d = new_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc00_q     <= '0;
            acc10_q     <= '0;
            acc01_q     <= '0;
            ovf_acc_q   <= 1'b0;
            m00_q       <= '0;
            m10_q       <= '0;
            m01_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc00_q     <= acc00_d;
            acc10_q     <= acc10_d;
            acc01_q     <= acc01_d;
            ovf_acc_q   <= ovf_acc_d;
            m00_q       <= m00_d;
            m10_q       <= m10_d;
            m01_q       <= m01_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign m00       = m00_q;
    assign m10       = m10_q;
    assign m01       = m01_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_centroid_moment_accu.sv
// Bench for centroid_moment_accu: directed frames plus random traffic against a frame-level pixel-list model.
module tb_centroid_moment_accu;

    localparam int XW = 11;
    localparam int YW = 11;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0, sof = 1'b0, eof = 1'b0, mask = 1'b0;
    logic [XW-1:0] x = '0;
    logic [YW-1:0] y = '0;
    logic [AW-1:0] m00, m10, m01;
    logic          ovf, out_valid;

    centroid_moment_accu #(.XW(XW), .YW(YW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .eof(eof), .mask(mask),
        .x(x), .y(y), .m00(m00), .m10(m10), .m01(m01), .ovf(ovf), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;

    // Reference model: list of masked pixels in the open frame; sums formed only at eof.
    logic [XW+YW-1:0] px_q[$];
    bit               in_frame = 1'b0;
    logic [AW-1:0]    exp_m00 = '0, exp_m10 = '0, exp_m01 = '0;
    logic             exp_ovf = 1'b0, exp_valid = 1'b0;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] fold(input longint t);
        longint lim = longint'(1) << AW;
`ifdef CENTROID_ACCU_SATURATE_EN
        return (t >= lim) ? {AW{1'b1}} : AW'(t);
`else
        return AW'(t % lim);
`endif
    endfunction

    task automatic publish_model();
        longint s0 = 0, s10 = 0, s01 = 0;
        longint lim = longint'(1) << AW;
        foreach (px_q[i]) begin
            s0  += 1;
            s10 += longint'(px_q[i][XW+YW-1:YW]);
            s01 += longint'(px_q[i][YW-1:0]);
        end
        exp_m00 = fold(s0);
        exp_m10 = fold(s10);
        exp_m01 = fold(s01);
        exp_ovf = (s0 >= lim) || (s10 >= lim) || (s01 >= lim);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " out_valid"}, AW'(out_valid), AW'(exp_valid));
        chk({tag, " m00"}, m00, exp_m00);
        chk({tag, " m10"}, m10, exp_m10);
        chk({tag, " m01"}, m01, exp_m01);
        chk({tag, " ovf"}, AW'(ovf), AW'(exp_ovf));
    endtask

    task automatic step(input string tag, input bit c, input bit s, input bit e, input bit m,
                        input int xi, input int yi);
        @(negedge clk);
        ce = c; sof = s; eof = e; mask = m; x = XW'(xi); y = YW'(yi);
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        if (c) begin
            if (s) begin
                px_q.delete();
                in_frame = 1'b1;
            end
            if (in_frame) begin
                if (m) px_q.push_back({XW'(xi), YW'(yi)});
                if (e) begin
                    publish_model();
                    exp_valid = 1'b1;
                    in_frame  = 1'b0;
                end
            end
        end
        if (out_valid) n_pulse++;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        in_frame = 1'b0;
        px_q.delete();
        exp_m00 = '0; exp_m10 = '0; exp_m01 = '0; exp_ovf = 1'b0; exp_valid = 1'b0;
        check_outputs(tag);
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Power-on reset
        do_reset("reset");

        // Pre-frame noise: eof without sof, and plain pixels, are ignored
        step("idle_eof", 1, 0, 1, 1, 9, 9);
        step("idle_pix", 1, 0, 0, 1, 4, 4);

        // Basic frame
        step("f1_sof", 1, 1, 0, 1, 0, 0);
        step("f1_p1",  1, 0, 0, 1, 3, 4);
        step("f1_gap", 0, 0, 1, 1, 100, 100);
        step("f1_p2",  1, 0, 0, 1, 5, 6);
        step("f1_eof", 1, 0, 1, 0, 1, 1);
        chk("f1 m00 const", m00, 12'd3);
        chk("f1 m10 const", m10, 12'd8);
        chk("f1 m01 const", m01, 12'd10);
        chk("f1 ovf const", AW'(ovf), '0);
        step("f1_hold", 1, 0, 0, 1, 50, 50);
        chk("f1 hold m10", m10, 12'd8);

        // One-pixel frame
        step("one_pix", 1, 1, 1, 1, 7, 9);
        chk("one m00 const", m00, 12'd1);
        chk("one m10 const", m10, 12'd7);
        chk("one m01 const", m01, 12'd9);

        // Restart mid-frame: exactly one pulse for the restarted frame
        n_pulse = 0;
        step("rs_sof", 1, 1, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step("rs_pix", 1, 0, 0, 1, 10 + i, 20 + i);
        step("rs_re",  1, 1, 0, 1, 2, 2);
        step("rs_eof", 1, 0, 1, 0, 0, 0);
        step("rs_idle", 1, 0, 0, 0, 0, 0);
        chk("rs m00 const", m00, 12'd1);
        chk("rs m10 const", m10, 12'd2);
        chk("rs pulses", AW'(n_pulse), 12'd1);

        // Overflow on m10: 3 x 2047 exceeds 12 bits
        step("ov_sof", 1, 1, 0, 1, 2047, 0);
        step("ov_p1",  1, 0, 0, 1, 2047, 0);
        step("ov_eof", 1, 0, 1, 1, 2047, 0);
`ifdef CENTROID_ACCU_SATURATE_EN
        chk("ov m10 const", m10, 12'd4095);
`else
        chk("ov m10 const", m10, 12'd2045);
`endif
        chk("ov ovf const", AW'(ovf), 12'd1);

        // Overflow flag clears on the next sof
        step("ovc_sof", 1, 1, 0, 1, 1, 2);
        step("ovc_eof", 1, 0, 1, 1, 3, 4);
        chk("ovc ovf const", AW'(ovf), '0);

        // ce=0 freezes everything, in IDLE and mid-frame
        for (int i = 0; i < 10; i++) step("frz_idle", 0, 1, 1, 1, 5, 5);
        step("frz_sof", 1, 1, 0, 1, 6, 7);
        for (int i = 0; i < 10; i++) step("frz_mid", 0, 1, 1, 1, 5, 5);
        step("frz_eof", 1, 0, 1, 1, 8, 9);
        chk("frz m00 const", m00, 12'd2);

        // Reset mid-frame discards the frame; later eof is ignored
        step("rm_sof", 1, 1, 0, 1, 30, 40);
        step("rm_pix", 1, 0, 0, 1, 31, 41);
        do_reset("rm_reset");
        step("rm_eof", 1, 0, 1, 1, 32, 42);
        step("rm_after", 1, 0, 0, 1, 33, 43);
        chk("rm m00 const", m00, '0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("rnd_reset");
            step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2047), $urandom_range(0, 2047));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/centroid_moment_accu.md
CENTROID_MOMENT_ACCU -- requirements
Module: centroid_moment_accu

Interface
REQ-001 Parameter XW, default 11, x-coordinate width in bits.
REQ-002 Parameter YW, default 11, y-coordinate width in bits.
REQ-003 Parameter AW, default 32, width of every accumulator and result; AW SHALL be at least max(XW,YW)+1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ce  in  1  pixel valid; pixel sampled only when ce=1.
REQ-007 sof  in  1  start of frame, qualified by ce.
REQ-008 eof  in  1  end of frame, qualified by ce.
REQ-009 mask  in  1  pixel belongs to object; contributes to the moments only when 1.
REQ-010 x  in  XW  unsigned column coordinate of the current pixel.
REQ-011 y  in  YW  unsigned row coordinate of the current pixel.
REQ-012 m00  out  AW  published count of masked pixels.
REQ-013 m10  out  AW  published sum of x over masked pixels.
REQ-014 m01  out  AW  published sum of y over masked pixels.
REQ-015 ovf  out  1  published overflow flag for the frame.
REQ-016 out_valid  out  1  one-cycle pulse marking new m00/m10/m01/ovf.

Function
REQ-017 FSM SHALL have two states, IDLE and ACCUM; IDLE after reset.
REQ-018 IDLE: ce=1 with sof=0 ignored; ce=1 with sof=1 clears accumulators, adds the current pixel if mask=1, and goes to ACCUM.
REQ-019 ACCUM: ce=1 with mask=1 adds 1 to acc00, x to acc10 and y to acc01 (zero-extended); ce=0 or mask=0 holds all accumulators.
REQ-020 ACCUM with ce=1, sof=1 and eof=0 SHALL restart the frame: discard the partial sums, load the current pixel's contribution, no out_valid, stay in ACCUM.
REQ-021 ce=1 with eof=1 in ACCUM, or with sof=1 and eof=1 in either state (one-pixel frame), SHALL do two things on that edge and return to IDLE:
- publish the accumulator value including the current pixel to m00/m10/m01/ovf;
- assert out_valid for exactly the following cycle.
REQ-022 eof in IDLE without sof SHALL be ignored: no publish, no pulse.
REQ-023 Published outputs SHALL hold their value until the next publish.
REQ-024 Latency from the eof sampling edge to out_valid high SHALL be 0 cycles, with outputs valid in the same cycle as out_valid.
REQ-025 A per-frame sticky overflow bit SHALL set when any addition carries out of AW bits, and SHALL clear on sof.
REQ-026 ce=0 SHALL freeze the FSM and accumulators regardless of sof/eof/mask.

Reset
REQ-027 While rst=0:
- state=IDLE;
- all accumulators, m00, m10, m01, ovf and out_valid = 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame; no out_valid follows deassertion.
REQ-029 The first frame after reset starts only on a ce=1, sof=1 sample.

Configuration
REQ-030 Macro CENTROID_ACCU_SATURATE_EN SHALL control overflow handling.
- Defined: an overflowing accumulator clamps to 2^AW-1 and stays there for the rest of the frame.
- Undefined: the accumulator wraps modulo 2^AW.
- In both builds the overflow bit is set per REQ-025.

Verification
REQ-031 Reset, then frame sof@(0,0) with mask=1, pixels (3,4) and (5,6) with mask=1, eof pixel (1,1) with mask=0 -> out_valid pulse; m00=3, m10=8, m01=10, ovf=0.
REQ-032 Single cycle with ce=1, sof=1, eof=1, mask=1, x=7, y=9 -> next cycle out_valid=1; m00=1, m10=7, m01=9.
REQ-033 Frame accumulating m00=5, then sof mid-frame at pixel (2,2) with mask=1, then eof pixel (0,0) with mask=0 -> m00=1, m10=2, m01=2; one pulse only.
REQ-034 AW=12, XW=11, three masked pixels with x=2047 -> m10 wraps to 2045 (macro undefined) or saturates to 4095 (macro defined); ovf=1 in both builds.
REQ-035 Reset asserted mid-frame, then eof with ce=1 -> no out_valid; all outputs remain 0.
REQ-036 ce=0 with sof=1 and eof=1 for 10 cycles -> no state change and no out_valid.
